// File: rtl/mainfsm.sv
// mainfsm - multicycle processor main control FSM (Moore).
//
// Sequences each instruction through FETCH / DECODE and then the memory,
// ALU or branch path. FETCH and MEMRD can be stretched by MEM_WAIT extra
// cycles (0..7) for slow memory. Write enables are qualified by the
// condition flag, so a failed-condition instruction still walks its full
// state sequence without side effects.
//
// Parameters:
//   MEM_WAIT   extra wait cycles in FETCH and MEMRD (0..7)
// Macro:
//   ILLEGAL_OP_TRAP_EN  when defined, op=11 enters TRAP and the illegal
//                       port exists; otherwise op=11 is a no-op.
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   op         instruction bits [27:26]
//   funct      instruction bits [25:20]
//   cond_ex    condition-passed flag
//   irwrite, adrsrc, alusrca, aluop   datapath controls
//   alusrcb, resultsrc                datapath mux selects
//   regwrite, memwrite, pcwrite       conditioned write enables
//   illegal    trap indicator (ILLEGAL_OP_TRAP_EN only)

module mainfsm #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       cond_ex,
    output logic       irwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic       aluop,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       regwrite,
    output logic       memwrite,
    output logic       pcwrite
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic       illegal
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        TRAP   = 4'd10
`endif
    } state_t;

    localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

    state_t     state, next_state;
    logic [2:0] wait_cnt, next_cnt;

    logic regw, memw, nextpc, branch, irw, nowrite;
`ifdef ILLEGAL_OP_TRAP_EN
    logic trap_st;
`endif

    // funct[2:1] carry no control information for this FSM.
    logic unused_funct;
    assign unused_funct = ^funct[2:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = '0;
        irw        = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 1'b0;
        aluop      = 1'b0;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        regw       = 1'b0;
        memw       = 1'b0;
        nextpc     = 1'b0;
        branch     = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
        trap_st    = 1'b0;
`endif
        case (state)
            FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                if (wait_cnt == WAIT_MAX) begin
                    irw        = 1'b1;
                    nextpc     = 1'b1;
                    next_state = DECODE;
                end else begin
                    next_cnt = wait_cnt + 3'd1;
                end
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                case (op)
                    2'b00:   next_state = funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
                    default: next_state = TRAP;
`else
                    default: next_state = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alusrcb    = 2'b01;
                next_state = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (wait_cnt == WAIT_MAX) begin
                    next_state = MEMWB;
                end else begin
                    next_cnt = wait_cnt + 3'd1;
                end
            end
            MEMWB: begin
                resultsrc  = 2'b01;
                regw       = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                adrsrc     = 1'b1;
                memw       = 1'b1;
                next_state = FETCH;
            end
            EXECR: begin
                aluop      = 1'b1;
                next_state = ALUWB;
            end
            EXECI: begin
                alusrcb    = 2'b01;
                aluop      = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: begin
                regw       = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrcb    = 2'b01;
                resultsrc  = 2'b10;
                branch     = 1'b1;
                next_state = FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP: begin
                trap_st    = 1'b1;
                next_state = TRAP;
            end
`endif
            default: next_state = FETCH;
        endcase
    end

    // Compare-class ALU ops (TST/TEQ/CMP/CMN) only set flags.
    assign nowrite  = (op == 2'b00) && (funct[4:3] == 2'b10);

    assign regwrite = regw & cond_ex & ~nowrite;
    assign memwrite = memw & cond_ex;
    // State is forced to FETCH during reset; with MEM_WAIT=0 that is the
    // final FETCH cycle, so the fetch strobes need explicit reset gating.
    assign irwrite  = irw & reset_n;
    assign pcwrite  = (nextpc | (branch & cond_ex)) & reset_n;
`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal  = trap_st & reset_n;
`endif

endmodule
